// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide sequencer.
// Holds funct3 encodings, the FSM state type and XLEN.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake between the execute stage
// (master) and the multiply/divide sequencer (slave).
interface muldiv_if;
  import muldiv_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_funct3, i_op1, i_op2, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_funct3, i_op1, i_op2, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, either a shift-add
// multiply step or a restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            i_div,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // remainder stays below the divisor, so 32 bits hold it between steps
  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_sh   = {i_hi, i_lo[XLEN-1]};
    w_ge   = (w_sh >= {1'b0, i_b});
    w_diff = w_sh[XLEN-1:0] - i_b;
    if (i_div) begin
      o_hi = w_ge ? w_diff : w_sh[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Define MULDIV_EARLY_OUT_EN to skip iteration for zero operands.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  muldiv_if.slave  bus
);
  localparam int S = STEPS_PER_CYCLE;
  localparam logic [5:0] N_CNT = 6'(XLEN / S);

  state_t          r_state;
  logic [5:0]      r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg1;
  logic            r_neg2;
  logic            r_div0;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;

  logic [S:0][XLEN-1:0] w_hi;
  logic [S:0][XLEN-1:0] w_lo;
  logic                 w_div;
  logic                 w_s1;
  logic                 w_s2;
  logic                 w_n1;
  logic                 w_n2;
  logic [XLEN-1:0]      w_a1;
  logic [XLEN-1:0]      w_a2;
  logic [2*XLEN-1:0]    w_prod;
  logic [2*XLEN-1:0]    w_p;
  logic [XLEN-1:0]      w_q;
  logic [XLEN-1:0]      w_r;
  logic [XLEN-1:0]      w_res;
  logic                 w_eo_hit;
  logic [XLEN-1:0]      w_eo_res;

  assign w_div = r_f3[2];
  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  for (genvar g = 0; g < S; g++) begin : g_step
    muldiv_step u_step (
      .i_div (w_div),
      .i_b   (r_b),
      .i_hi  (w_hi[g]),
      .i_lo  (w_lo[g]),
      .o_hi  (w_hi[g+1]),
      .o_lo  (w_lo[g+1])
    );
  end

  always_comb begin
    w_s1 = (bus.i_funct3 == F3_MULH) || (bus.i_funct3 == F3_MULHSU) ||
           (bus.i_funct3 == F3_DIV)  || (bus.i_funct3 == F3_REM);
    w_s2 = (bus.i_funct3 == F3_MULH) || (bus.i_funct3 == F3_DIV) ||
           (bus.i_funct3 == F3_REM);
    w_n1 = w_s1 && bus.i_op1[XLEN-1];
    w_n2 = w_s2 && bus.i_op2[XLEN-1];
    w_a1 = w_n1 ? -bus.i_op1 : bus.i_op1;
    w_a2 = w_n2 ? -bus.i_op2 : bus.i_op2;
  end

  // a zero divisor keeps the all-ones quotient regardless of sign
  always_comb begin
    w_prod = {w_hi[S], w_lo[S]};
    w_p    = (r_neg1 ^ r_neg2) ? -w_prod : w_prod;
    w_q    = ((r_neg1 ^ r_neg2) && !r_div0) ? -w_lo[S] : w_lo[S];
    w_r    = r_neg1 ? -w_hi[S] : w_hi[S];
    unique case (r_f3)
      F3_MUL:                       w_res = w_p[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_res = w_p[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_res = w_q;
      default:                      w_res = w_r;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    w_eo_hit = bus.i_funct3[2] ? (bus.i_op2 == '0)
                               : (bus.i_op1 == '0 || bus.i_op2 == '0);
    w_eo_res = '0;
    if (bus.i_funct3[2])
      w_eo_res = bus.i_funct3[1] ? bus.i_op1 : '1;
  end
`else
  assign w_eo_hit = 1'b0;
  assign w_eo_res = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_div0   <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.i_valid) begin
          r_f3   <= bus.i_funct3;
          r_neg1 <= w_n1;
          r_neg2 <= w_n2;
          r_div0 <= (bus.i_op2 == '0);
          r_b    <= bus.i_funct3[2] ? w_a2 : w_a1;
          r_lo   <= bus.i_funct3[2] ? w_a1 : w_a2;
          r_hi   <= '0;
          if (w_eo_hit) begin
            r_result <= w_eo_res;
            r_state  <= ST_DONE;
          end else begin
            r_cnt   <= N_CNT;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_hi  <= w_hi[S];
          r_lo  <= w_lo[S];
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= w_res;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: if (bus.i_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (r_state == ST_IDLE);
  assign bus.o_valid  = (r_state == ST_DONE);
  assign bus.o_busy   = (r_state != ST_IDLE);
  assign bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq with hand-computed
// results, latency, backpressure and mid-operation reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 33;
`endif
  localparam int LAT = 33;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  muldiv_if bus ();

  muldiv_seq #(.STEPS_PER_CYCLE(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input int lat, input string tag);
    int cyc;
    int rdy;
    bus.i_funct3 = f3;
    bus.i_op1    = a;
    bus.i_op2    = b;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cyc = 1;
    rdy = 0;
    while (!bus.o_valid && cyc < 100) begin
      if (bus.o_ready || !bus.o_busy) rdy++;
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.o_ready) rdy++;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_rdy"}, rdy, 0);
    chk(tag, bus.o_result, exp);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk({tag, "_idle"}, {31'b0, bus.o_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    int bad;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_funct3 = '0;
    bus.i_op1    = '0;
    bus.i_op2    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rst_busy",  {31'b0, bus.o_busy},  32'd0);
    chk("rst_res",   bus.o_result, 32'd0);

    run(F3_MUL,    32'd7,        32'd6,        32'd42,       LAT,  "mul");
    run(F3_MUL,    32'h12345678, 32'h10,       32'h23456780, LAT,  "mul2");
    run(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT,  "mulh");
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT,  "mulhu");
    run(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT,  "mulhsu");
    run(F3_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, LAT,  "mulh_min");
    run(F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT,  "div");
    run(F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT,  "rem");
    run(F3_DIVU,   32'd100,      32'd7,        32'd14,       LAT,  "divu");
    run(F3_REMU,   32'd100,      32'd7,        32'd2,        LAT,  "remu");
    run(F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT0, "divu0");
    run(F3_REM,    32'd5,        32'd0,        32'd5,        LAT0, "rem0");
    run(F3_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, LAT0, "div0n");
    run(F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT0, "rem0n");
    run(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT,  "div_ovf");
    run(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT,  "rem_ovf");

    // backpressure with a competing request
    bus.i_funct3 = F3_MUL;
    bus.i_op1    = 32'd7;
    bus.i_op2    = 32'd6;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cyc = 1;
    while (!bus.o_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_lat", cyc, LAT);
    bus.i_funct3 = F3_MUL;
    bus.i_op1    = 32'd3;
    bus.i_op2    = 32'd4;
    bus.i_valid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_result !== 32'd42 || bus.o_ready || !bus.o_valid) bad++;
      @(posedge clk); #1;
    end
    chk("bp_hold", bad, 0);
    chk("bp_res", bus.o_result, 32'd42);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("bp_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("bp_valid", {31'b0, bus.o_valid}, 32'd0);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_noacc", {31'b0, bus.o_busy}, 32'd0);

    // reset in the middle of a divide
    bus.i_funct3 = F3_DIVU;
    bus.i_op1    = 32'd100;
    bus.i_op2    = 32'd7;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("abort_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("abort_res",   bus.o_result, 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_valid || bus.o_busy) bad++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", bad, 0);
    run(F3_MUL, 32'd3, 32'd4, 32'd12, LAT, "mul_post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
